fetch_queue_stage: RTL
======================

FETCH_QUEUE_STAGE -- requirements
Module: fetch_queue_stage

Interface
REQ-001 Parameter WORD_SIZE, default `WORD_SIZE (32), width of PC and instruction words.
REQ-002 Parameter QUEUE_DEPTH, default 4, prefetch queue entries; power of two, 2..16.
REQ-003 Parameter PC_INITIAL, default `PC_INITIAL (0), PC value loaded by reset.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 PCSrcE  in  1  redirect request from execute stage.
REQ-007 PCTargetE  in  WORD_SIZE  redirect target address.
REQ-008 IMemReqF  out  1  instruction memory read request, always accepted by memory.
REQ-009 IMemAddrF  out  WORD_SIZE  read address, valid when IMemReqF=1.
REQ-010 IMemRdataF  in  WORD_SIZE  read data, valid exactly one cycle after its request.
REQ-011 InstrD  out  WORD_SIZE  instruction at queue head.
REQ-012 PCD  out  WORD_SIZE  PC of InstrD.
REQ-013 PCPlus4D  out  WORD_SIZE  PCD+4.
REQ-014 ValidD  out  1  queue head valid.
REQ-015 ReadyD  in  1  decode accepts head; transfer when ValidD && ReadyD.
REQ-016 QueueCountF  out  $clog2(QUEUE_DEPTH)+1  entries currently held.

Function
REQ-017 Fetch PC register (PCF) drives IMemAddrF; IMemReqF=1 iff !rst && !PCSrcE && QueueCountF + inflight < QUEUE_DEPTH, inflight=1 if a request was issued last cycle and not squashed.
REQ-018 On an issued request, PCF <= PCF+4 (modulo 2^WORD_SIZE, wrap-around silent); otherwise PCF holds.
REQ-019 A request's PC is held in an in-flight register; next cycle {IMemRdataF, PC, PC+4} is pushed into the queue.
REQ-020 Queue is FIFO; head drives InstrD/PCD/PCPlus4D/ValidD from registers (no combinational path from IMemRdataF to outputs).
REQ-021 Push and pop in the same cycle are both performed; count unchanged.
REQ-022 Credit rule of REQ-017 guarantees no push when full; overflow is impossible by construction.
REQ-023 Pop when empty is impossible (ValidD=0); ReadyD ignored when ValidD=0.
REQ-024 Outputs InstrD/PCD/PCPlus4D hold stable while ValidD=1 and ReadyD=0.
REQ-025 Redirect (PCSrcE=1): PCF <= {PCTargetE[WORD_SIZE-1:2],2'b00}; queue emptied; in-flight response discarded next cycle; no request this cycle; no pop this cycle.
REQ-026 Redirect has priority over push, pop and issue; ValidD=0 the cycle after redirect.
REQ-027 Latency: request in cycle N -> ValidD=1 with that instruction in cycle N+2 when queue was empty.
REQ-028 Steady-state throughput one instruction per cycle with ReadyD held high.
REQ-029 Pointers wrap modulo QUEUE_DEPTH; count distinguishes full from empty.

Reset
REQ-030 With rst=1 at posedge: PCF=PC_INITIAL, queue empty, inflight=0.
REQ-031 During rst=1: IMemReqF=0, ValidD=0, QueueCountF=0, InstrD=PCD=PCPlus4D=0.
REQ-032 Reset mid-operation discards queue contents and in-flight response; first request after release uses PC_INITIAL.

Structure
REQ-033 WORD_SIZE and PC_INITIAL defaults come from shared constants.v; no new package constants.
REQ-034 Queue storage/pointers/count in one sub-module instr_fifo (parametrised width, depth, push, pop, flush).
REQ-035 Expected size 150-300 lines RTL total.

Verification (WORD_SIZE=32, QUEUE_DEPTH=4, PC_INITIAL=0, memory returns addr|0xA000_0000)
REQ-036 Release reset, ReadyD=1 -> cycle0 IMemAddrF=0; cycle2 ValidD=1, InstrD=0xA0000000, PCD=0, PCPlus4D=4; then PCD=4,8,12 on consecutive cycles.
REQ-037 ReadyD=0 from release -> exactly 4 requests (0,4,8,12), QueueCountF reaches 4, IMemReqF=0 thereafter, PCD holds 0.
REQ-038 Full queue, ReadyD pulsed one cycle -> one pop, one new request addr 16, count returns to 4, no overflow.
REQ-039 PCSrcE=1 with PCTargetE=0x103 while 3 entries queued and one in flight -> next cycle ValidD=0, count 0, stale response dropped; IMemAddrF=0x100, ValidD=1 with PCD=0x100 two cycles later.
REQ-040 PCF=0xFFFFFFFC -> next request addr 0, PCPlus4D of that entry =0.
REQ-041 Assert rst for one cycle with full queue -> ValidD=0, count 0; after release first IMemAddrF=0.

Source files
------------

// File: rtl/fetch_queue_stage_pkg.sv
// fetch_queue_stage_pkg
//   Shared types for the fetch queue slice. WORD_SIZE and PC_INITIAL
//   normally come from the shared constants.v. The guarded fallbacks below
//   hold the same values, so this slice still builds when that file is not
//   on the compile line.
//   Ports: none (package).

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef PC_INITIAL
`define PC_INITIAL 0
`endif

package fetch_queue_stage_pkg;

  // FIFO operation for one cycle, encoded as {push, pop}.
  typedef enum logic [1:0] {
    FQ_IDLE = 2'b00,
    FQ_POP  = 2'b01,
    FQ_PUSH = 2'b10,
    FQ_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fetch_queue_stage_instr_fifo.sv
// instr_fifo
//   Circular FIFO for fetched instruction entries. Depth is a power of two,
//   so the pointers wrap by natural overflow. The count tells full from
//   empty. Flush empties the queue in one cycle. The head entry is read
//   directly from the storage registers.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     flush                 empty the queue (takes priority over push/pop)
//     push, push_data       write one entry at the tail
//     pop                   drop the head entry (ignored when empty)
//     head_data             entry at the head of the queue
//     count                 number of entries held

module instr_fifo
  import fetch_queue_stage_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop_ok;
  fifo_op_e          op;

  assign pop_ok    = pop && (count != '0);
  assign op        = fifo_op_e'({push, pop_ok});
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (op)
        FQ_PUSH: begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          count  <= count + CNT_W'(1);
        end
        FQ_POP: begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          count  <= count - CNT_W'(1);
        end
        FQ_BOTH: begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Storage holds data only and is never reset.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage
//   Prefetching fetch stage. The fetch PC issues one read per cycle while
//   credit is available. Each response returns one cycle after its request
//   and is queued together with its PC and PC+4. Decode consumes the queue
//   head through a valid/ready handshake. A redirect from execute realigns
//   the PC, empties the queue and drops any response still in flight.
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     PCSrcE, PCTargetE            redirect request and target
//     IMemReqF, IMemAddrF          instruction memory read request/address
//     IMemRdataF                   read data, one cycle after its request
//     InstrD, PCD, PCPlus4D        queue head entry (zero when not valid)
//     ValidD, ReadyD               head valid / decode accepts
//     QueueCountF                  entries currently queued

module fetch_queue_stage
  import fetch_queue_stage_pkg::*;
#(
  parameter int                   WORD_SIZE   = `WORD_SIZE,
  parameter int                   QUEUE_DEPTH = 4,
  parameter logic [WORD_SIZE-1:0] PC_INITIAL  = WORD_SIZE'(`PC_INITIAL)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         PCSrcE,
  input  logic [WORD_SIZE-1:0]         PCTargetE,
  output logic                         IMemReqF,
  output logic [WORD_SIZE-1:0]         IMemAddrF,
  input  logic [WORD_SIZE-1:0]         IMemRdataF,
  output logic [WORD_SIZE-1:0]         InstrD,
  output logic [WORD_SIZE-1:0]         PCD,
  output logic [WORD_SIZE-1:0]         PCPlus4D,
  output logic                         ValidD,
  input  logic                         ReadyD,
  output logic [$clog2(QUEUE_DEPTH):0] QueueCountF
);

  localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1;
  localparam int USE_W  = CNT_W + 1;
  localparam int ENTRY_W = 3 * WORD_SIZE;

  logic [WORD_SIZE-1:0] pc_p0;
  logic                 inflight_vld_p1;
  logic [WORD_SIZE-1:0] inflight_pc_p1;

  logic [CNT_W-1:0]     queue_count;
  logic [ENTRY_W-1:0]   head_data;
  logic [ENTRY_W-1:0]   push_data;
  logic [USE_W-1:0]     credit_used;
  logic                 issue;
  logic                 push;
  logic                 pop;
  logic                 head_vld;

  // Queued entries plus an outstanding response must leave room for one
  // more entry. This way a response always finds space when it returns.
  assign credit_used = USE_W'(queue_count) + USE_W'(inflight_vld_p1);
  assign issue       = !rst && !PCSrcE && (credit_used < USE_W'(QUEUE_DEPTH));

  assign push     = !rst && !PCSrcE && inflight_vld_p1;
  assign head_vld = !rst && (queue_count != '0);
  assign pop      = !PCSrcE && head_vld && ReadyD;

  assign push_data = {IMemRdataF, inflight_pc_p1, inflight_pc_p1 + WORD_SIZE'(4)};

  // ---- stage p0: fetch PC and request issue ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0 <= PC_INITIAL;
    end else if (PCSrcE) begin
      pc_p0 <= {PCTargetE[WORD_SIZE-1:2], 2'b00};
    end else if (issue) begin
      pc_p0 <= pc_p0 + WORD_SIZE'(4);
    end
  end

  assign IMemReqF  = issue;
  assign IMemAddrF = pc_p0;

  // ---- stage p1: request in flight, response arrives ----
  // A redirect cycle never issues, so the valid bit clears on its own.
  // The response that lands in that cycle is then dropped by the gated push.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_vld_p1 <= 1'b0;
    end else begin
      inflight_vld_p1 <= issue;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      inflight_pc_p1 <= pc_p0;
    end
  end

  // ---- stage p2: prefetch queue, head drives decode ----
  instr_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (QUEUE_DEPTH)
  ) u_instr_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (PCSrcE),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (queue_count)
  );

  assign ValidD      = head_vld;
  assign QueueCountF = rst ? '0 : queue_count;
  assign InstrD      = head_vld ? head_data[3*WORD_SIZE-1:2*WORD_SIZE] : '0;
  assign PCD         = head_vld ? head_data[2*WORD_SIZE-1:WORD_SIZE]   : '0;
  assign PCPlus4D    = head_vld ? head_data[WORD_SIZE-1:0]             : '0;

endmodule
